// File: rtl/wb_stage.sv
// Write-back stage: commits register-file writes, owns the CP0 subset and
// resolves precise exceptions, interrupts and ERET for the whole pipeline.
package io_stage_params;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] final_result;
    logic        register_file_write_enabled;
    logic [3:0]  register_file_write_strobe;
    logic [4:0]  register_file_address;
    logic        move_from_cp0;
    logic        move_to_cp0;
    logic [4:0]  cp0_address_register;
    logic [2:0]  cp0_address_select;
    logic        exception_valid;
    logic [4:0]  exception_code;
    logic        is_address_fault;
    logic [31:0] badvaddr_value;
    logic        eret_flush;
    logic        in_delay_slot;
  } io_to_wb_bus_t;
endpackage

package wb_stage_params;
  typedef struct packed {
    logic        exception_valid;
    logic        eret_flush;
    logic [31:0] redirect_target;
  } wb_exception_bus_t;
endpackage

module wb_stage #(
  parameter logic [31:0] EXCEPTION_ENTRY = 32'hBFC0_0380,
  parameter int unsigned COUNT_DIVIDE    = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  io_stage_params::io_to_wb_bus_t    io_to_wb_bus,
  output logic                              wb_allow_in,
  input  logic [5:0]                        hardware_interrupt,
  output logic [3:0]                        register_file_write_strobe,
  output logic [4:0]                        register_file_write_address,
  output logic [31:0]                       register_file_write_data,
  output wb_stage_params::wb_exception_bus_t wb_exception_bus,
  output logic                              wb_have_exception,
  output logic [31:0]                       debug_wb_program_count
);

  localparam int unsigned DIV_W = (COUNT_DIVIDE > 1) ? $clog2(COUNT_DIVIDE) : 1;

  localparam logic [7:0] CP0_BADVADDR = {5'd8, 3'd0};
  localparam logic [7:0] CP0_COUNT    = {5'd9, 3'd0};
  localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

  logic                          wb_valid;
  io_stage_params::io_to_wb_bus_t wb_bus;

  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  logic        cause_bd;
  logic        cause_ti;
  logic [1:0]  cause_ip_soft;
  logic [4:0]  cause_exc_code;
  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [DIV_W-1:0] divider;

  logic        stage_valid;
  logic [7:0]  cause_ip;
  logic        interrupt_pending;
  logic        take_exception;
  logic        take_eret;
  logic [4:0]  exception_code;
  logic [7:0]  cp0_index;
  logic        mtc0_write;
  logic        divider_wrap;
  logic [31:0] status_value;
  logic [31:0] cause_value;
  logic [31:0] cp0_read_data;

  // The payload valid bit is 1 whenever wb_valid was loaded high, so folding
  // it in keeps flag and payload consistent without changing behaviour.
  assign stage_valid = wb_valid && wb_bus.valid;

  assign cause_ip          = {cause_ti | hardware_interrupt[5], hardware_interrupt[4:0], cause_ip_soft};
  assign interrupt_pending = status_ie && !status_exl && |(cause_ip & status_im);
  assign take_exception    = stage_valid && (wb_bus.exception_valid || interrupt_pending);
  assign take_eret         = stage_valid && wb_bus.eret_flush && !take_exception;
  assign exception_code    = interrupt_pending ? 5'h00 : wb_bus.exception_code;
  assign cp0_index         = {wb_bus.cp0_address_register, wb_bus.cp0_address_select};
  assign mtc0_write        = stage_valid && wb_bus.move_to_cp0 && !take_exception;
  assign divider_wrap      = (divider == DIV_W'(COUNT_DIVIDE - 1));

  assign status_value = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
  assign cause_value  = {cause_bd, cause_ti, 14'b0, cause_ip, 1'b0, cause_exc_code, 2'b00};

  always_comb begin
    // NOTE: a default before the case keeps this purely combinational; any
    // path that skipped the assignment would infer a latch.
    cp0_read_data = '0;
    case (cp0_index)
      CP0_BADVADDR: cp0_read_data = badvaddr;
      CP0_COUNT:    cp0_read_data = count;
      CP0_COMPARE:  cp0_read_data = compare;
      CP0_STATUS:   cp0_read_data = status_value;
      CP0_CAUSE:    cp0_read_data = cause_value;
      CP0_EPC:      cp0_read_data = epc;
      default:      cp0_read_data = '0;
    endcase
  end

  assign wb_allow_in                  = 1'b1;
  assign register_file_write_strobe   = (stage_valid && wb_bus.register_file_write_enabled &&
                                         !take_exception && !take_eret)
                                        ? wb_bus.register_file_write_strobe : 4'h0;
  assign register_file_write_address  = wb_bus.register_file_address;
  assign register_file_write_data     = wb_bus.move_from_cp0 ? cp0_read_data : wb_bus.final_result;
  assign debug_wb_program_count       = wb_bus.pc;
  assign wb_have_exception            = stage_valid &&
                                        (wb_bus.exception_valid || wb_bus.eret_flush || interrupt_pending);

  always_comb begin
    wb_exception_bus.exception_valid = take_exception;
    wb_exception_bus.eret_flush      = take_eret;
    wb_exception_bus.redirect_target = take_eret ? epc : (take_exception ? EXCEPTION_ENTRY : 32'h0);
  end

  // A flush kills whatever io is handing over on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      wb_valid <= 1'b0;
      wb_bus   <= '0;
    end else begin
      wb_valid <= (take_exception || take_eret) ? 1'b0 : io_to_wb_bus.valid;
      if (io_to_wb_bus.valid) wb_bus <= io_to_wb_bus;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      status_im  <= '0;
      status_exl <= 1'b0;
      status_ie  <= 1'b0;
    end else begin
      if (take_exception)  status_exl <= 1'b1;
      else if (take_eret)  status_exl <= 1'b0;
      if (mtc0_write && cp0_index == CP0_STATUS) begin
        status_im  <= wb_bus.final_result[15:8];
        status_exl <= wb_bus.final_result[1];
        status_ie  <= wb_bus.final_result[0];
      end
    end
  end

  // TI compares pre-edge Count/Compare; a Compare write acknowledges it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cause_bd       <= 1'b0;
      cause_ti       <= 1'b0;
      cause_ip_soft  <= '0;
      cause_exc_code <= '0;
    end else begin
      if (take_exception) begin
        if (!status_exl) cause_bd <= wb_bus.in_delay_slot;
        cause_exc_code <= exception_code;
      end
      if (mtc0_write && cp0_index == CP0_COMPARE) cause_ti <= 1'b0;
      else if (count == compare)                  cause_ti <= 1'b1;
      if (mtc0_write && cp0_index == CP0_CAUSE) cause_ip_soft <= wb_bus.final_result[9:8];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      epc      <= '0;
      badvaddr <= '0;
      compare  <= '0;
    end else begin
      if (take_exception) begin
        if (!status_exl) epc <= wb_bus.in_delay_slot ? wb_bus.pc - 32'd4 : wb_bus.pc;
        if (wb_bus.is_address_fault) badvaddr <= wb_bus.badvaddr_value;
      end
      if (mtc0_write && cp0_index == CP0_EPC)     epc     <= wb_bus.final_result;
      if (mtc0_write && cp0_index == CP0_COMPARE) compare <= wb_bus.final_result;
    end
  end

  // A software write to Count takes precedence over the divided tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      divider <= '0;
      count   <= '0;
    end else begin
      divider <= divider_wrap ? '0 : divider + 1'b1;
      if (mtc0_write && cp0_index == CP0_COUNT) count <= wb_bus.final_result;
      else if (divider_wrap)                    count <= count + 32'd1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus random traffic,
// all compared against a field-level behavioural model of the CP0 subset.
module tb_wb_stage;
  import io_stage_params::*;
  import wb_stage_params::*;

  localparam int unsigned COUNT_DIVIDE = 2;
  localparam logic [31:0] ENTRY        = 32'hBFC0_0380;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  io_to_wb_bus_t     bus = '0;
  logic [5:0]        hw  = '0;
  logic              wb_allow_in;
  logic [3:0]        register_file_write_strobe;
  logic [4:0]        register_file_write_address;
  logic [31:0]       register_file_write_data;
  wb_exception_bus_t wb_exception_bus;
  logic              wb_have_exception;
  logic [31:0]       debug_wb_program_count;

  wb_stage #(.EXCEPTION_ENTRY(ENTRY), .COUNT_DIVIDE(COUNT_DIVIDE)) dut (
    .clock                       (clock),
    .reset                       (reset),
    .io_to_wb_bus                (bus),
    .wb_allow_in                 (wb_allow_in),
    .hardware_interrupt          (hw),
    .register_file_write_strobe  (register_file_write_strobe),
    .register_file_write_address (register_file_write_address),
    .register_file_write_data    (register_file_write_data),
    .wb_exception_bus            (wb_exception_bus),
    .wb_have_exception           (wb_have_exception),
    .debug_wb_program_count      (debug_wb_program_count)
  );

  // {strobe, addr, data, exc_valid, eret, target, have_exc, pc}
  logic [107:0] obs;
  assign obs = {register_file_write_strobe, register_file_write_address, register_file_write_data,
                wb_exception_bus.exception_valid, wb_exception_bus.eret_flush,
                wb_exception_bus.redirect_target, wb_have_exception, debug_wb_program_count};

  int n_cmp  = 0;
  int n_fail = 0;
  logic [107:0] exp_out;

  logic [4:0] exc_codes [6] = '{5'h4, 5'h5, 5'h8, 5'h9, 5'hA, 5'hC};
  logic [4:0] cp0_regs  [6] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};

  // ---------------- behavioural model ----------------
  logic          m_valid;
  io_to_wb_bus_t m_w;
  logic          m_ie, m_exl, m_bd, m_ti;
  logic [7:0]    m_im;
  logic [1:0]    m_sw;
  logic [4:0]    m_code;
  logic [31:0]   m_count, m_compare, m_epc, m_badv;
  int            m_ticks;

  function automatic void model_reset();
    m_valid = 1'b0; m_w = '0;
    m_ie = 1'b0; m_exl = 1'b0; m_bd = 1'b0; m_ti = 1'b0;
    m_im = '0; m_sw = '0; m_code = '0;
    m_count = '0; m_compare = '0; m_epc = '0; m_badv = '0;
    m_ticks = 0;
  endfunction

  function automatic logic [7:0] model_ip();
    return {m_ti | hw[5], hw[4:0], m_sw};
  endfunction

  function automatic logic model_pending();
    return m_ie && !m_exl && ((model_ip() & m_im) != 8'h00);
  endfunction

  function automatic logic [31:0] model_cp0(input logic [4:0] r, input logic [2:0] s);
    if (s != 3'd0) return 32'h0;
    case (r)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return 32'h0040_0000 + 32'(m_im) * 256 + 32'(m_exl) * 2 + 32'(m_ie);
      5'd13:   return 32'(m_bd) * 32'h8000_0000 + 32'(m_ti) * 32'h4000_0000
                      + 32'(model_ip()) * 256 + 32'(m_code) * 4;
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [107:0] model_outputs();
    logic pend, te, tr, have;
    logic [31:0] target, data;
    logic [3:0] strobe;
    pend   = model_pending();
    te     = m_valid && (m_w.exception_valid || pend);
    tr     = m_valid && m_w.eret_flush && !te;
    target = tr ? m_epc : (te ? ENTRY : 32'h0);
    strobe = (m_valid && m_w.register_file_write_enabled && !te && !tr) ? m_w.register_file_write_strobe : 4'h0;
    data   = m_w.move_from_cp0 ? model_cp0(m_w.cp0_address_register, m_w.cp0_address_select) : m_w.final_result;
    have   = m_valid && (m_w.exception_valid || m_w.eret_flush || pend);
    return {strobe, m_w.register_file_address, data, te, tr, target, have, m_w.pc};
  endfunction

  // What one rising edge does, given the inputs currently applied.
  task automatic step_model();
    logic pend, te, tr, wr, hit;
    logic [4:0] r;
    pend = model_pending();
    te   = m_valid && (m_w.exception_valid || pend);
    tr   = m_valid && m_w.eret_flush && !te;
    wr   = m_valid && m_w.move_to_cp0 && !te && (m_w.cp0_address_select == 3'd0);
    r    = m_w.cp0_address_register;
    hit  = (m_count == m_compare);
    if (te) begin
      if (!m_exl) begin
        m_epc = m_w.in_delay_slot ? m_w.pc - 32'd4 : m_w.pc;
        m_bd  = m_w.in_delay_slot;
      end
      m_exl  = 1'b1;
      m_code = pend ? 5'h0 : m_w.exception_code;
      if (m_w.is_address_fault) m_badv = m_w.badvaddr_value;
    end else if (tr) begin
      m_exl = 1'b0;
    end
    m_ticks++;
    if (wr && r == 5'd9) m_count = m_w.final_result;
    else if (m_ticks % COUNT_DIVIDE == 0) m_count = m_count + 32'd1;
    if (wr && r == 5'd11) begin m_compare = m_w.final_result; m_ti = 1'b0; end
    else if (hit) m_ti = 1'b1;
    if (wr && r == 5'd12) begin
      m_im = m_w.final_result[15:8]; m_exl = m_w.final_result[1]; m_ie = m_w.final_result[0];
    end
    if (wr && r == 5'd13) m_sw = m_w.final_result[9:8];
    if (wr && r == 5'd14) m_epc = m_w.final_result;
    m_valid = (te || tr) ? 1'b0 : bus.valid;
    if (bus.valid) m_w = bus;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input io_to_wb_bus_t b, input logic [5:0] h);
    bus = b; hw = h;
    #1;
    exp_out = model_outputs();
  endtask

  task automatic tick();
    step_model();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic io_to_wb_bus_t alu(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] rd);
    io_to_wb_bus_t b = '0;
    b.valid = 1'b1; b.pc = pc; b.final_result = res; b.register_file_address = rd;
    b.register_file_write_enabled = 1'b1; b.register_file_write_strobe = 4'hF;
    return b;
  endfunction

  function automatic io_to_wb_bus_t mfc0(input logic [4:0] r);
    io_to_wb_bus_t b = alu(32'hBFC0_1000, 32'h0, 5'd7);
    b.move_from_cp0 = 1'b1; b.cp0_address_register = r;
    return b;
  endfunction

  function automatic io_to_wb_bus_t mtc0(input logic [4:0] r, input logic [31:0] v);
    io_to_wb_bus_t b = '0;
    b.valid = 1'b1; b.pc = 32'hBFC0_2000; b.final_result = v;
    b.move_to_cp0 = 1'b1; b.cp0_address_register = r;
    return b;
  endfunction

  function automatic io_to_wb_bus_t rand_instr();
    io_to_wb_bus_t b = '0;
    int kind;
    b.valid = ($urandom_range(0, 3) != 0);
    b.pc = $urandom & 32'hFFFF_FFFC;
    b.final_result = $urandom;
    b.register_file_write_enabled = 1'($urandom_range(0, 1));
    b.register_file_write_strobe  = 4'($urandom_range(0, 15));
    b.register_file_address       = 5'($urandom_range(0, 31));
    b.in_delay_slot               = 1'($urandom_range(0, 1));
    kind = int'($urandom_range(0, 19));
    if (kind < 2) begin
      b.exception_valid  = 1'b1;
      b.exception_code   = exc_codes[$urandom_range(0, 5)];
      b.is_address_fault = (b.exception_code == 5'h4 || b.exception_code == 5'h5);
      b.badvaddr_value   = $urandom;
    end else if (kind == 2) begin
      b.eret_flush = 1'b1;
    end else if (kind < 10) begin
      if (kind < 6) b.move_to_cp0 = 1'b1; else b.move_from_cp0 = 1'b1;
      b.cp0_address_register = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31))
                                                            : cp0_regs[$urandom_range(0, 5)];
      b.cp0_address_select   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      if (b.move_to_cp0 && b.cp0_address_register == 5'd11) b.final_result = m_count + 32'($urandom_range(0, 8));
    end
    return b;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clock);
    drive('0, 6'h0);
    n_cmp++; if (obs !== 108'h0) begin n_fail++; $display("FAIL reset.outputs_zero: got %h expected 0", obs); end
    n_cmp++; if (wb_allow_in !== 1'b1) begin n_fail++; $display("FAIL reset.allow_in: got %b expected 1", wb_allow_in); end
    @(posedge clock); @(negedge clock);
    reset = 1'b1;
    drive(mfc0(5'd12), 6'h0);
    n_cmp++; if (obs !== exp_out) begin n_fail++; $display("FAIL reset.model: got %h expected %h", obs, exp_out); end
    tick();
    drive('0, 6'h0);
    n_cmp++; if (register_file_write_data !== 32'h0040_0000) begin n_fail++;
      $display("FAIL reset.status_value: got %h expected 00400000", register_file_write_data); end
    tick();
  endtask

  task automatic test_plain_commit();
    drive(alu(32'hBFC0_0010, 32'h1234_5678, 5'd5), 6'h0);
    n_cmp++; if (obs !== exp_out) begin n_fail++; $display("FAIL commit.model: got %h expected %h", obs, exp_out); end
    tick();
    drive('0, 6'h0);
    n_cmp++; if (obs !== exp_out) begin n_fail++; $display("FAIL commit.model2: got %h expected %h", obs, exp_out); end
    n_cmp++;
    if ({register_file_write_strobe, register_file_write_address, register_file_write_data, wb_exception_bus.exception_valid}
        !== {4'hF, 5'd5, 32'h1234_5678, 1'b0}) begin
      n_fail++; $display("FAIL commit.rf: got strobe %h addr %0d data %h exc %b expected F 5 12345678 0",
                         register_file_write_strobe, register_file_write_address, register_file_write_data,
                         wb_exception_bus.exception_valid);
    end
    tick();
  endtask

  task automatic test_address_fault();
    io_to_wb_bus_t b = alu(32'hBFC0_0100, 32'hDEAD_BEEF, 5'd8);
    b.exception_valid = 1'b1; b.exception_code = 5'h4; b.is_address_fault = 1'b1; b.badvaddr_value = 32'h8000_0003;
    drive(b, 6'h0); tick();
    drive(alu(32'hBFC0_0104, 32'h1111_1111, 5'd9), 6'h0);
    n_cmp++; if (obs !== exp_out) begin n_fail++; $display("FAIL fault.model: got %h expected %h", obs, exp_out); end
    n_cmp++;
    if ({wb_exception_bus.exception_valid, wb_exception_bus.redirect_target, register_file_write_strobe} !== {1'b1, ENTRY, 4'h0}) begin
      n_fail++; $display("FAIL fault.redirect: got exc %b target %h strobe %h expected 1 %h 0",
                         wb_exception_bus.exception_valid, wb_exception_bus.redirect_target, register_file_write_strobe, ENTRY);
    end
    tick();
    drive(mfc0(5'd14), 6'h0);
    n_cmp++; if ({register_file_write_strobe, wb_have_exception} !== 5'h0) begin n_fail++;
      $display("FAIL fault.flushed_next: got strobe %h have %b expected 0 0", register_file_write_strobe, wb_have_exception); end
    tick();
    drive(mfc0(5'd8), 6'h0);
    n_cmp++; if (register_file_write_data !== 32'hBFC0_0100) begin n_fail++;
      $display("FAIL fault.epc: got %h expected bfc00100", register_file_write_data); end
    tick();
    drive(mfc0(5'd13), 6'h0);
    n_cmp++; if (register_file_write_data !== 32'h8000_0003) begin n_fail++;
      $display("FAIL fault.badvaddr: got %h expected 80000003", register_file_write_data); end
    tick();
    drive(mfc0(5'd12), 6'h0);
    n_cmp++; if (register_file_write_data[6:2] !== 5'h4) begin n_fail++;
      $display("FAIL fault.exccode: got %h expected 4", register_file_write_data[6:2]); end
    tick();
    drive('0, 6'h0);
    n_cmp++; if (register_file_write_data[1] !== 1'b1) begin n_fail++;
      $display("FAIL fault.exl: got %b expected 1", register_file_write_data[1]); end
    tick();
  endtask

  task automatic test_delay_slot_eret();
    io_to_wb_bus_t b = alu(32'hBFC0_0204, 32'h0, 5'd0);
    drive(mtc0(5'd12, 32'h0), 6'h0); tick();
    b.register_file_write_enabled = 1'b0; b.in_delay_slot = 1'b1;
    b.exception_valid = 1'b1; b.exception_code = 5'h8;
    drive(b, 6'h0); tick();
    drive('0, 6'h0);
    n_cmp++; if (obs !== exp_out) begin n_fail++; $display("FAIL dslot.model: got %h expected %h", obs, exp_out); end
    tick();
    drive(mfc0(5'd14), 6'h0); tick();
    drive(mfc0(5'd13), 6'h0);
    n_cmp++; if (register_file_write_data !== 32'hBFC0_0200) begin n_fail++;
      $display("FAIL dslot.epc: got %h expected bfc00200", register_file_write_data); end
    tick();
    b = '0; b.valid = 1'b1; b.pc = 32'hBFC0_0390; b.eret_flush = 1'b1;
    drive(b, 6'h0);
    n_cmp++; if (register_file_write_data[31] !== 1'b1) begin n_fail++;
      $display("FAIL dslot.bd: got %b expected 1", register_file_write_data[31]); end
    tick();
    drive('0, 6'h0);
    n_cmp++;
    if ({wb_exception_bus.exception_valid, wb_exception_bus.eret_flush, wb_exception_bus.redirect_target} !== {2'b01, 32'hBFC0_0200}) begin
      n_fail++; $display("FAIL dslot.eret: got exc %b eret %b target %h expected 0 1 bfc00200",
                         wb_exception_bus.exception_valid, wb_exception_bus.eret_flush, wb_exception_bus.redirect_target);
    end
    tick();
    drive(mfc0(5'd12), 6'h0); tick();
    drive('0, 6'h0);
    n_cmp++; if (register_file_write_data[1] !== 1'b0) begin n_fail++;
      $display("FAIL dslot.exl_cleared: got %b expected 0", register_file_write_data[1]); end
    tick();
  endtask

  task automatic test_timer_interrupt();
    drive(mtc0(5'd9, 32'd0), 6'h0); tick();
    drive(mtc0(5'd11, 32'd3), 6'h0); tick();
    drive(mtc0(5'd12, 32'h0000_8001), 6'h0); tick();
    for (int i = 0; i < 12; i++) begin
      drive('0, 6'h0);
      n_cmp++; if (obs !== exp_out) begin n_fail++; $display("FAIL timer.wait[%0d]: got %h expected %h", i, obs, exp_out); end
      tick();
    end
    drive(alu(32'hBFC0_0300, 32'h5555_AAAA, 5'd2), 6'h0); tick();
    drive('0, 6'h0);
    n_cmp++;
    if ({wb_exception_bus.exception_valid, wb_exception_bus.redirect_target, register_file_write_strobe} !== {1'b1, ENTRY, 4'h0}) begin
      n_fail++; $display("FAIL timer.interrupt: got exc %b target %h strobe %h expected 1 %h 0",
                         wb_exception_bus.exception_valid, wb_exception_bus.redirect_target, register_file_write_strobe, ENTRY);
    end
    tick();
    drive(mfc0(5'd13), 6'h0); tick();
    drive(mtc0(5'd11, 32'd1000), 6'h0);
    n_cmp++; if ({register_file_write_data[30], register_file_write_data[6:2]} !== 6'b1_00000) begin n_fail++;
      $display("FAIL timer.cause: got ti %b code %h expected 1 0", register_file_write_data[30], register_file_write_data[6:2]); end
    tick();
    drive(mfc0(5'd13), 6'h0); tick();
    drive('0, 6'h0);
    n_cmp++; if (register_file_write_data[30] !== 1'b0) begin n_fail++;
      $display("FAIL timer.ti_cleared: got %b expected 0", register_file_write_data[30]); end
    tick();
  endtask

  task automatic test_mtc0_vs_interrupt();
    drive(mtc0(5'd12, 32'h0000_0401), 6'h0); tick();
    drive(mtc0(5'd12, 32'h0000_FF00), 6'h0); tick();
    drive('0, 6'h01);
    n_cmp++; if (obs !== exp_out) begin n_fail++; $display("FAIL mtc0_int.model: got %h expected %h", obs, exp_out); end
    n_cmp++; if ({wb_exception_bus.exception_valid, wb_have_exception} !== 2'b11) begin n_fail++;
      $display("FAIL mtc0_int.taken: got exc %b have %b expected 1 1", wb_exception_bus.exception_valid, wb_have_exception); end
    tick();
    drive(mfc0(5'd12), 6'h0); tick();
    drive('0, 6'h0);
    n_cmp++; if (register_file_write_data !== 32'h0040_0403) begin n_fail++;
      $display("FAIL mtc0_int.status: got %h expected 00400403", register_file_write_data); end
    tick();
  endtask

  task automatic test_random();
    logic [5:0] h = '0;
    drive(mtc0(5'd12, 32'h0000_FF01), 6'h0); tick();
    for (int i = 0; i < 800; i++) begin
      if (i % 16 == 0) h = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'h0;
      drive(rand_instr(), h);
      n_cmp++; if (obs !== exp_out) begin n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, obs, exp_out); end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    io_to_wb_bus_t b = mtc0(5'd12, 32'h0000_FF03);
    b.register_file_write_enabled = 1'b1; b.register_file_write_strobe = 4'hF;
    drive(b, 6'h0); tick();
    drive('0, 6'h0);
    n_cmp++; if (obs !== exp_out) begin n_fail++; $display("FAIL midreset.before: got %h expected %h", obs, exp_out); end
    #2 reset = 1'b0;
    #1 model_reset();
    n_cmp++; if (obs !== 108'h0) begin n_fail++; $display("FAIL midreset.async_zero: got %h expected 0", obs); end
    @(posedge clock); @(negedge clock);
    reset = 1'b1;
    drive(mfc0(5'd12), 6'h0);
    n_cmp++; if (obs !== exp_out) begin n_fail++; $display("FAIL midreset.model: got %h expected %h", obs, exp_out); end
    tick();
    drive('0, 6'h0);
    n_cmp++; if (register_file_write_data !== 32'h0040_0000) begin n_fail++;
      $display("FAIL midreset.status: got %h expected 00400000", register_file_write_data); end
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_plain_commit();
    test_address_fault();
    test_delay_slot_eret();
    test_timer_interrupt();
    test_mtc0_vs_interrupt();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
